// File: rtl/alu_ctr_muldiv.sv
// ALU control decode for the MIPS execute stage plus an iterative multiply/divide
// unit owning HI/LO, with a pipeline stall while an MDU operation is in flight.
//
// state  | meaning
// S_IDLE | no operation in flight; MDU instructions execute or start here
// S_MUL  | radix-2 shift-add multiply, one multiplier bit per cycle
// S_DIV  | restoring divide, one quotient bit per cycle
module alu_ctr_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic             valid,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [3:0]       alu_ctr,
    output logic             mdu_sel,
    output logic [WIDTH-1:0] mdu_rdata,
    output logic             stall,
    output logic             busy
);

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] acc_hi;   // partial product high half / partial remainder
    logic [WIDTH-1:0] acc_lo;   // multiplier being shifted out / dividend-quotient
    logic [WIDTH-1:0] opnd;     // multiplicand or divisor magnitude
    logic             neg_q;
    logic             neg_r;

    always_comb begin
        alu_ctr = 4'b0010;
        case (alu_op)
            2'b00: alu_ctr = 4'b0010;
            2'b01: alu_ctr = 4'b0110;
            2'b11: alu_ctr = 4'b0000;
            default: begin
                case (funct)
                    6'b100000: alu_ctr = 4'b0010;
                    6'b100010: alu_ctr = 4'b0110;
                    6'b100100: alu_ctr = 4'b0000;
                    6'b100101: alu_ctr = 4'b0001;
                    6'b101010: alu_ctr = 4'b0111;
                    6'b100110: alu_ctr = 4'b0011;
                    6'b100111: alu_ctr = 4'b1100;
                    default:   alu_ctr = 4'b0010;
                endcase
            end
        endcase
    end

    logic r_type;
    logic is_mdu;
    logic act;
    logic op_mthi;
    logic op_mtlo;
    logic op_mul;
    logic op_div;
    logic is_signed;
    logic rs_neg;
    logic rt_neg;
    logic [WIDTH-1:0] rs_mag;
    logic [WIDTH-1:0] rt_mag;

    assign r_type  = (alu_op == 2'b10);
    assign is_mdu  = r_type && ((funct[5:2] == 4'b0100) || (funct[5:2] == 4'b0110));
    assign stall   = valid & busy & is_mdu;
    assign act     = valid & ~stall & is_mdu;
    assign op_mthi = act && (funct == F_MTHI);
    assign op_mtlo = act && (funct == F_MTLO);
    assign op_mul  = act && ((funct == F_MULT) || (funct == F_MULTU));
    assign op_div  = act && ((funct == F_DIV)  || (funct == F_DIVU));

    // Signed variants have funct[0] clear for both mult and div.
    assign is_signed = ~funct[0];
    assign rs_neg    = is_signed & rs_val[WIDTH-1];
    assign rt_neg    = is_signed & rt_val[WIDTH-1];
    assign rs_mag    = rs_neg ? -rs_val : rs_val;
    assign rt_mag    = rt_neg ? -rt_val : rt_val;

    assign mdu_sel = r_type && ((funct == F_MFHI) || (funct == F_MFLO));

    always_comb begin
        mdu_rdata = '0;
        if (r_type && (funct == F_MFHI))
            mdu_rdata = hi;
        else if (r_type && (funct == F_MFLO))
            mdu_rdata = lo;
    end

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_hi_nxt;
    logic [WIDTH-1:0]   mul_lo_nxt;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;

    assign mul_sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    assign mul_hi_nxt = mul_sum[WIDTH:1];
    assign mul_lo_nxt = {mul_sum[0], acc_lo[WIDTH-1:1]};
    assign prod       = {mul_hi_nxt, mul_lo_nxt};
    assign prod_fix   = neg_q ? -prod : prod;

    // Partial remainder is always below the divisor, so the top bit of the
    // difference is a clean borrow flag.
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ok;
    logic [WIDTH-1:0] div_rem_nxt;
    logic [WIDTH-1:0] div_q_nxt;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    assign div_shift   = {acc_hi, acc_lo[WIDTH-1]};
    assign div_diff    = div_shift - {1'b0, opnd};
    assign div_ok      = ~div_diff[WIDTH];
    assign div_rem_nxt = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_q_nxt   = {acc_lo[WIDTH-2:0], div_ok};
    assign quo_fix     = neg_q ? -div_q_nxt : div_q_nxt;
    assign rem_fix     = neg_r ? -div_rem_nxt : div_rem_nxt;

    logic last;
    assign last = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (op_mthi)
                        hi <= rs_val;
                    if (op_mtlo)
                        lo <= rs_val;
                    if (op_mul) begin
                        state  <= S_MUL;
                        busy   <= 1'b1;
                        cnt    <= '0;
                        acc_hi <= '0;
                        acc_lo <= rt_mag;
                        opnd   <= rs_mag;
                        neg_q  <= rs_neg ^ rt_neg;
                        neg_r  <= rs_neg;
                    end
                    if (op_div) begin
                        if (rt_val == '0) begin
                            hi <= rs_val;
                            lo <= '1;
                        end else begin
                            state  <= S_DIV;
                            busy   <= 1'b1;
                            cnt    <= '0;
                            acc_hi <= '0;
                            acc_lo <= rs_mag;
                            opnd   <= rt_mag;
                            neg_q  <= rs_neg ^ rt_neg;
                            neg_r  <= rs_neg;
                        end
                    end
                end
                S_MUL: begin
                    acc_hi <= mul_hi_nxt;
                    acc_lo <= mul_lo_nxt;
                    cnt    <= cnt + CNT_W'(1);
                    if (last) begin
                        hi    <= prod_fix[2*WIDTH-1:WIDTH];
                        lo    <= prod_fix[WIDTH-1:0];
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_DIV: begin
                    acc_hi <= div_rem_nxt;
                    acc_lo <= div_q_nxt;
                    cnt    <= cnt + CNT_W'(1);
                    if (last) begin
                        hi    <= rem_fix;
                        lo    <= quo_fix;
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctr_muldiv.sv
// Directed bench for alu_ctr_muldiv: decode table, HI/LO moves, multiply/divide
// results, stall timing, divide by zero and asynchronous reset mid-operation.
module tb_alu_ctr_muldiv;

    localparam logic [1:0] OP_R    = 2'b10;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic        clk;
    logic        rst_n;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic        valid;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [3:0]  alu_ctr;
    logic        mdu_sel;
    logic [31:0] mdu_rdata;
    logic        stall;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    alu_ctr_muldiv #(.WIDTH(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_op    (alu_op),
        .funct     (funct),
        .valid     (valid),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .alu_ctr   (alu_ctr),
        .mdu_sel   (mdu_sel),
        .mdu_rdata (mdu_rdata),
        .stall     (stall),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called just after a falling edge; leaves the outputs settled.
    task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] rs, input logic [31:0] rt);
        valid  = v;
        alu_op = op;
        funct  = fn;
        rs_val = rs;
        rt_val = rt;
        #1;
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            cycle();
            n++;
        end
        check_val({tag, "_done"}, {31'b0, busy}, 32'd0);
    endtask

    logic [1:0] dec_op  [12];
    logic [5:0] dec_fn  [12];
    logic [3:0] dec_exp [12];

    initial begin
        int n;
        int s;

        dec_op[0]  = 2'b00; dec_fn[0]  = 6'b100010; dec_exp[0]  = 4'b0010;
        dec_op[1]  = 2'b01; dec_fn[1]  = 6'b100000; dec_exp[1]  = 4'b0110;
        dec_op[2]  = 2'b11; dec_fn[2]  = 6'b100000; dec_exp[2]  = 4'b0000;
        dec_op[3]  = OP_R;  dec_fn[3]  = 6'b100000; dec_exp[3]  = 4'b0010;
        dec_op[4]  = OP_R;  dec_fn[4]  = 6'b100010; dec_exp[4]  = 4'b0110;
        dec_op[5]  = OP_R;  dec_fn[5]  = 6'b100100; dec_exp[5]  = 4'b0000;
        dec_op[6]  = OP_R;  dec_fn[6]  = 6'b100101; dec_exp[6]  = 4'b0001;
        dec_op[7]  = OP_R;  dec_fn[7]  = 6'b101010; dec_exp[7]  = 4'b0111;
        dec_op[8]  = OP_R;  dec_fn[8]  = 6'b100110; dec_exp[8]  = 4'b0011;
        dec_op[9]  = OP_R;  dec_fn[9]  = 6'b100111; dec_exp[9]  = 4'b1100;
        dec_op[10] = OP_R;  dec_fn[10] = 6'b000000; dec_exp[10] = 4'b0010;
        dec_op[11] = OP_R;  dec_fn[11] = F_MULT;    dec_exp[11] = 4'b0010;

        rst_n = 1'b0;
        drive(1'b1, OP_R, F_MFHI, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        check_val("rst_busy",  {31'b0, busy},    32'd0);
        check_val("rst_stall", {31'b0, stall},   32'd0);
        check_val("rst_sel",   {31'b0, mdu_sel}, 32'd1);
        check_val("rst_hi",    mdu_rdata,        32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            drive(1'b0, dec_op[i], dec_fn[i], 32'h0, 32'h0);
            check_val($sformatf("dec_%0d", i), {28'b0, alu_ctr}, {28'b0, dec_exp[i]});
        end

        // mthi then mfhi back to back
        drive(1'b1, OP_R, F_MTHI, 32'hA5A5_A5A5, 32'h0);
        check_val("mthi_stall", {31'b0, stall}, 32'd0);
        cycle();
        drive(1'b1, OP_R, F_MFHI, 32'h0, 32'h0);
        check_val("mfhi_stall", {31'b0, stall}, 32'd0);
        check_val("mfhi_val",   mdu_rdata,      32'hA5A5_A5A5);

        // mult -3 * 7 with mflo waiting behind it
        drive(1'b1, OP_R, F_MULT, 32'hFFFF_FFFD, 32'd7);
        check_val("mult_issue_stall", {31'b0, stall}, 32'd0);
        cycle();
        drive(1'b1, OP_R, F_MFLO, 32'h0, 32'h0);
        n = 0;
        s = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            if (stall === 1'b1) s++;
            cycle();
        end
        check_val("mult_busy_cycles",  n, 32'd32);
        check_val("mult_stall_cycles", s, 32'd32);
        check_val("mult_after_stall",  {31'b0, stall}, 32'd0);
        check_val("mult_lo", mdu_rdata, 32'hFFFF_FFEB);
        drive(1'b1, OP_R, F_MFHI, 32'h0, 32'h0);
        check_val("mult_hi", mdu_rdata, 32'hFFFF_FFFF);

        // ALU instructions alongside a busy multiply never stall
        drive(1'b1, OP_R, F_MULT, 32'd3, 32'd4);
        cycle();
        drive(1'b1, 2'b00, 6'b000000, 32'd1, 32'd2);
        check_val("add_busy",  {31'b0, busy},  32'd1);
        check_val("add_stall", {31'b0, stall}, 32'd0);
        check_val("add_ctr",   {28'b0, alu_ctr}, 32'h2);
        cycle();
        drive(1'b1, OP_R, 6'b100010, 32'd1, 32'd2);
        check_val("sub_stall", {31'b0, stall}, 32'd0);
        check_val("sub_ctr",   {28'b0, alu_ctr}, 32'h6);
        drive(1'b1, OP_R, F_MFLO, 32'h0, 32'h0);
        check_val("mflo_busy_stall", {31'b0, stall}, 32'd1);
        wait_idle("mult34");
        check_val("mult34_lo", mdu_rdata, 32'd12);

        // divu 100 / 7
        drive(1'b1, OP_R, F_DIVU, 32'd100, 32'd7);
        cycle();
        drive(1'b1, OP_R, F_MFLO, 32'h0, 32'h0);
        check_val("divu_busy", {31'b0, busy}, 32'd1);
        wait_idle("divu");
        check_val("divu_lo", mdu_rdata, 32'd14);
        drive(1'b1, OP_R, F_MFHI, 32'h0, 32'h0);
        check_val("divu_hi", mdu_rdata, 32'd2);

        // div -7 / 2
        drive(1'b1, OP_R, F_DIV, 32'hFFFF_FFF9, 32'd2);
        cycle();
        drive(1'b1, OP_R, F_MFLO, 32'h0, 32'h0);
        wait_idle("div_neg");
        check_val("div_neg_lo", mdu_rdata, 32'hFFFF_FFFD);
        drive(1'b1, OP_R, F_MFHI, 32'h0, 32'h0);
        check_val("div_neg_hi", mdu_rdata, 32'hFFFF_FFFF);

        // divide by zero: no iteration
        drive(1'b1, OP_R, F_DIV, 32'h1234_5678, 32'h0);
        cycle();
        drive(1'b1, OP_R, F_MFHI, 32'h0, 32'h0);
        check_val("dz_busy",  {31'b0, busy},  32'd0);
        check_val("dz_stall", {31'b0, stall}, 32'd0);
        check_val("dz_hi",    mdu_rdata,      32'h1234_5678);
        drive(1'b1, OP_R, F_MFLO, 32'h0, 32'h0);
        check_val("dz_lo",    mdu_rdata,      32'hFFFF_FFFF);

        // signed overflow
        drive(1'b1, OP_R, F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        cycle();
        drive(1'b1, OP_R, F_MFLO, 32'h0, 32'h0);
        wait_idle("ovf");
        check_val("ovf_lo", mdu_rdata, 32'h8000_0000);
        drive(1'b1, OP_R, F_MFHI, 32'h0, 32'h0);
        check_val("ovf_hi", mdu_rdata, 32'h0);

        // reset in the middle of a multiply
        drive(1'b1, OP_R, F_MULT, 32'hFFFF_FFFD, 32'd7);
        cycle();
        drive(1'b1, OP_R, F_MFHI, 32'h0, 32'h0);
        repeat (10) cycle();
        check_val("mid_busy",  {31'b0, busy},  32'd1);
        check_val("mid_stall", {31'b0, stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("arst_busy",  {31'b0, busy},  32'd0);
        check_val("arst_stall", {31'b0, stall}, 32'd0);
        check_val("arst_hi",    mdu_rdata,      32'h0);
        drive(1'b1, OP_R, F_MFLO, 32'h0, 32'h0);
        check_val("arst_lo",    mdu_rdata,      32'h0);
        cycle();
        rst_n = 1'b1;
        drive(1'b1, OP_R, F_MULTU, 32'd5, 32'd6);
        cycle();
        drive(1'b1, OP_R, F_MFLO, 32'h0, 32'h0);
        check_val("multu_busy", {31'b0, busy}, 32'd1);
        wait_idle("multu");
        check_val("multu_lo", mdu_rdata, 32'd30);
        drive(1'b1, OP_R, F_MFHI, 32'h0, 32'h0);
        check_val("multu_hi", mdu_rdata, 32'd0);

        drive(1'b0, 2'b00, 6'b000000, 32'h0, 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
